// File: rtl/dp_ram_bw_if.sv
// Bus bundle for the dp_ram_bw dual-port RAM.
//  Ports A and B carry the same signal set:
//   *_cs, *_we, *_be[NB], *_addr[ADDR_WIDTH], *_wdata[DATA_WIDTH]  (master -> RAM)
//   *_rdata[DATA_WIDTH], *_rvalid                                 (RAM -> master)
//  master: the agent driving the RAM.  slave: the RAM itself.
interface dp_ram_bw_if #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32
);
  localparam int NB = DATA_WIDTH / 8;

  logic                  a_cs,   b_cs;
  logic                  a_we,   b_we;
  logic [NB-1:0]         a_be,   b_be;
  logic [ADDR_WIDTH-1:0] a_addr, b_addr;
  logic [DATA_WIDTH-1:0] a_wdata, b_wdata;
  logic [DATA_WIDTH-1:0] a_rdata, b_rdata;
  logic                  a_rvalid, b_rvalid;

  modport master (
    output a_cs, a_we, a_be, a_addr, a_wdata,
    output b_cs, b_we, b_be, b_addr, b_wdata,
    input  a_rdata, a_rvalid, b_rdata, b_rvalid
  );

  modport slave (
    input  a_cs, a_we, a_be, a_addr, a_wdata,
    input  b_cs, b_we, b_be, b_addr, b_wdata,
    output a_rdata, a_rvalid, b_rdata, b_rvalid
  );
endinterface

// File: rtl/dp_ram_bw.sv
// dp_ram_bw: true dual-port synchronous RAM with per-byte write enables.
//  Ports:
//   clk        rising-edge clock
//   rst        async active-high reset (read pipelines and outputs only)
//   bus        dp_ram_bw_if.slave, ports A and B (cs/we/be/addr/wdata in,
//              rdata/rvalid out)
//   init_busy  memory clear in progress
//  Parameters: ADDR_WIDTH, DATA_WIDTH (multiple of 8), DEPTH (<= 2**ADDR_WIDTH),
//   RD_LATENCY (1 or 2), RDW_MODE (cross-port read-during-write: 0 old, 1 new).
//  Optional feature macro: DP_RAM_BW_INIT_CLEAR_EN -- after reset the memory
//   is zeroed one word per cycle (IDLE -> CLEAR -> READY) with init_busy high
//   and all port accesses ignored until it finishes.
//  Same-address writes from both ports merge per byte, port A winning overlaps.
//  Out-of-range writes are dropped; out-of-range reads return 0 with rvalid.

// Per-port read output stage: optional extra register for RD_LATENCY=2,
// then the rdata/rvalid output register. rdata only updates on a valid read.
module dp_ram_bw_rdpipe #(
  parameter int DW  = 32,
  parameter int LAT = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          rd,
  input  logic [DW-1:0] word,
  output logic [DW-1:0] rdata,
  output logic          rvalid
);
  logic          s_vld;
  logic [DW-1:0] s_dat;

  if (LAT == 2) begin : g_lat2
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        s_vld <= 1'b0;
        s_dat <= '0;
      end else begin
        s_vld <= rd;
        s_dat <= word;
      end
    end
  end else begin : g_lat1
    assign s_vld = rd;
    assign s_dat = word;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rvalid <= 1'b0;
      rdata  <= '0;
    end else begin
      rvalid <= s_vld;
      if (s_vld) rdata <= s_dat;
    end
  end
endmodule

module dp_ram_bw #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 1 << ADDR_WIDTH,
  parameter int RD_LATENCY = 1,
  parameter int RDW_MODE   = 0
) (
  input  logic           clk,
  input  logic           rst,
  dp_ram_bw_if.slave     bus,
  output logic           init_busy
);
  localparam int NB = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];

  logic                  ready;
  logic                  clr_we;
  logic [ADDR_WIDTH-1:0] clr_addr;

  function automatic logic [DATA_WIDTH-1:0] merge(
    input logic [DATA_WIDTH-1:0] old,
    input logic [DATA_WIDTH-1:0] wd,
    input logic [NB-1:0]         be
  );
    logic [DATA_WIDTH-1:0] r;
    r = old;
    for (int i = 0; i < NB; i++)
      if (be[i]) r[8*i +: 8] = wd[8*i +: 8];
    return r;
  endfunction

`ifdef DP_RAM_BW_INIT_CLEAR_EN
  typedef enum logic [1:0] {IDLE, CLEAR, READY} state_t;
  localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(DEPTH - 1);

  state_t                state;
  logic [ADDR_WIDTH-1:0] clr_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      clr_cnt   <= '0;
      init_busy <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          state     <= CLEAR;
          clr_cnt   <= '0;
          init_busy <= 1'b1;
        end
        CLEAR: begin
          if (clr_cnt == LAST) begin
            state     <= READY;
            init_busy <= 1'b0;
          end else begin
            clr_cnt <= clr_cnt + 1'b1;
          end
        end
        READY:   ;
        default: state <= IDLE;
      endcase
    end
  end

  // IDLE also blocks access: the memory is about to be wiped anyway.
  assign ready    = (state == READY);
  assign clr_we   = (state == CLEAR);
  assign clr_addr = clr_cnt;
`else
  assign ready     = 1'b1;
  assign clr_we    = 1'b0;
  assign clr_addr  = '0;
  assign init_busy = 1'b0;
`endif

  logic a_in, b_in;
  if (DEPTH >= (1 << ADDR_WIDTH)) begin : g_full
    assign a_in = 1'b1;
    assign b_in = 1'b1;
  end else begin : g_part
    assign a_in = (32'(bus.a_addr) < DEPTH);
    assign b_in = (32'(bus.b_addr) < DEPTH);
  end

  logic a_wr, b_wr, a_rd, b_rd, same;
  assign a_wr = ready & bus.a_cs &  bus.a_we & a_in;
  assign b_wr = ready & bus.b_cs &  bus.b_we & b_in;
  assign a_rd = ready & bus.a_cs & ~bus.a_we;
  assign b_rd = ready & bus.b_cs & ~bus.b_we;
  assign same = (bus.a_addr == bus.b_addr);

  logic [DATA_WIDTH-1:0] a_old, b_old, a_new, b_new, a_rword, b_rword;

  always_comb begin
    a_old = a_in ? mem[bus.a_addr] : '0;
    b_old = b_in ? mem[bus.b_addr] : '0;
    // A's word is built on top of B's so a same-address collision keeps
    // B's bytes where A has no enable and A's bytes where both do.
    b_new = merge(b_old, bus.b_wdata, bus.b_be);
    a_new = merge((b_wr && same) ? b_new : a_old, bus.a_wdata, bus.a_be);

    a_rword = a_old;
    b_rword = b_old;
    if (RDW_MODE == 1) begin
      if (b_wr && same) a_rword = merge(a_old, bus.b_wdata, bus.b_be);
      if (a_wr && same) b_rword = merge(b_old, bus.a_wdata, bus.a_be);
    end
    if (!a_in) a_rword = '0;
    if (!b_in) b_rword = '0;
  end

  // Storage has no reset; the last assignment to a word wins (A over B).
  always_ff @(posedge clk) begin
    if (clr_we) mem[clr_addr] <= '0;
    if (b_wr)   mem[bus.b_addr] <= b_new;
    if (a_wr)   mem[bus.a_addr] <= a_new;
  end

  dp_ram_bw_rdpipe #(.DW(DATA_WIDTH), .LAT(RD_LATENCY)) u_rd_a (
    .clk(clk), .rst(rst), .rd(a_rd), .word(a_rword),
    .rdata(bus.a_rdata), .rvalid(bus.a_rvalid)
  );

  dp_ram_bw_rdpipe #(.DW(DATA_WIDTH), .LAT(RD_LATENCY)) u_rd_b (
    .clk(clk), .rst(rst), .rd(b_rd), .word(b_rword),
    .rdata(bus.b_rdata), .rvalid(bus.b_rvalid)
  );
endmodule

// File: tb/tb_dp_ram_bw.sv
// Testbench for dp_ram_bw. Two instances:
//  dut0: DEPTH=12, RD_LATENCY=1, RDW_MODE=0 (also exercises out-of-range)
//  dut1: DEPTH=16, RD_LATENCY=2, RDW_MODE=1
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_dp_ram_bw;
  logic clk = 1'b0;
  logic rst0, rst1;
  logic busy0, busy1;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  dp_ram_bw_if #(.ADDR_WIDTH(4), .DATA_WIDTH(32)) i0 ();
  dp_ram_bw_if #(.ADDR_WIDTH(4), .DATA_WIDTH(32)) i1 ();

  dp_ram_bw #(.ADDR_WIDTH(4), .DATA_WIDTH(32), .DEPTH(12), .RD_LATENCY(1), .RDW_MODE(0))
    dut0 (.clk(clk), .rst(rst0), .bus(i0), .init_busy(busy0));
  dp_ram_bw #(.ADDR_WIDTH(4), .DATA_WIDTH(32), .DEPTH(16), .RD_LATENCY(2), .RDW_MODE(1))
    dut1 (.clk(clk), .rst(rst1), .bus(i1), .init_busy(busy1));

  task automatic idle();
    i0.a_cs = 0; i0.a_we = 0; i0.a_be = '0; i0.a_addr = '0; i0.a_wdata = '0;
    i0.b_cs = 0; i0.b_we = 0; i0.b_be = '0; i0.b_addr = '0; i0.b_wdata = '0;
    i1.a_cs = 0; i1.a_we = 0; i1.a_be = '0; i1.a_addr = '0; i1.a_wdata = '0;
    i1.b_cs = 0; i1.b_we = 0; i1.b_be = '0; i1.b_addr = '0; i1.b_wdata = '0;
  endtask

  // One-cycle access on dut0 (pb selects port B); returns on the falling
  // edge after the capturing rising edge.
  task automatic op0(input bit pb, input bit we, input logic [3:0] addr,
                     input logic [31:0] d, input logic [3:0] be);
    if (!pb) begin
      i0.a_cs = 1; i0.a_we = we; i0.a_addr = addr; i0.a_wdata = d; i0.a_be = be;
    end else begin
      i0.b_cs = 1; i0.b_we = we; i0.b_addr = addr; i0.b_wdata = d; i0.b_be = be;
    end
    @(negedge clk);
    idle();
  endtask

  task automatic op1(input bit pb, input bit we, input logic [3:0] addr,
                     input logic [31:0] d, input logic [3:0] be);
    if (!pb) begin
      i1.a_cs = 1; i1.a_we = we; i1.a_addr = addr; i1.a_wdata = d; i1.a_be = be;
    end else begin
      i1.b_cs = 1; i1.b_we = we; i1.b_addr = addr; i1.b_wdata = d; i1.b_be = be;
    end
    @(negedge clk);
    idle();
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    @(negedge clk);
    while ((busy0 || busy1) && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (busy0 || busy1) begin
      errors++;
      $display("FAIL wait_ready: init_busy still high after %0d cycles", n);
    end
  endtask

  task automatic test_reset();
    checks++; if (i0.a_rdata !== 32'h0 || i0.a_rvalid !== 1'b0) begin errors++;
      $display("FAIL reset_d0_a: rdata=%h rvalid=%b want 0/0", i0.a_rdata, i0.a_rvalid); end
    checks++; if (i0.b_rdata !== 32'h0 || i0.b_rvalid !== 1'b0) begin errors++;
      $display("FAIL reset_d0_b: rdata=%h rvalid=%b want 0/0", i0.b_rdata, i0.b_rvalid); end
    checks++; if (i1.a_rdata !== 32'h0 || i1.a_rvalid !== 1'b0) begin errors++;
      $display("FAIL reset_d1_a: rdata=%h rvalid=%b want 0/0", i1.a_rdata, i1.a_rvalid); end
    checks++; if (i1.b_rdata !== 32'h0 || i1.b_rvalid !== 1'b0) begin errors++;
      $display("FAIL reset_d1_b: rdata=%h rvalid=%b want 0/0", i1.b_rdata, i1.b_rvalid); end
    checks++; if (busy0 !== 1'b0 || busy1 !== 1'b0) begin errors++;
      $display("FAIL reset_busy: busy0=%b busy1=%b want 0/0", busy0, busy1); end
    rst0 = 0; rst1 = 0;
    wait_ready();
  endtask

  task automatic test_write_read();
    op0(0, 1, 4'd3, 32'hDEADBEEF, 4'hF);
    checks++; if (i0.a_rvalid !== 1'b0) begin errors++;
      $display("FAIL write_no_rvalid: a_rvalid=%b want 0", i0.a_rvalid); end
    op0(1, 0, 4'd3, 32'h0, 4'h0);
    checks++; if (i0.b_rvalid !== 1'b1 || i0.b_rdata !== 32'hDEADBEEF) begin errors++;
      $display("FAIL b_read3: rvalid=%b rdata=%h want 1/deadbeef", i0.b_rvalid, i0.b_rdata); end
    @(negedge clk);
    checks++; if (i0.b_rvalid !== 1'b0 || i0.b_rdata !== 32'hDEADBEEF) begin errors++;
      $display("FAIL b_hold: rvalid=%b rdata=%h want 0/deadbeef", i0.b_rvalid, i0.b_rdata); end
  endtask

  task automatic test_byte_enable();
    op0(0, 1, 4'd5, 32'h11223344, 4'hF);
    op0(0, 1, 4'd5, 32'hAABBCCDD, 4'b0101);
    op0(0, 0, 4'd5, 32'h0, 4'h0);
    checks++; if (i0.a_rvalid !== 1'b1 || i0.a_rdata !== 32'h11BB33DD) begin errors++;
      $display("FAIL byte_en: rvalid=%b rdata=%h want 1/11bb33dd", i0.a_rvalid, i0.a_rdata); end
    op0(0, 1, 4'd5, 32'hFFFFFFFF, 4'h0);
    checks++; if (i0.a_rvalid !== 1'b0) begin errors++;
      $display("FAIL be0_no_rvalid: a_rvalid=%b want 0", i0.a_rvalid); end
    op0(0, 0, 4'd5, 32'h0, 4'hF);
    checks++; if (i0.a_rdata !== 32'h11BB33DD) begin errors++;
      $display("FAIL be0_no_change: rdata=%h want 11bb33dd", i0.a_rdata); end
  endtask

  task automatic test_rdw();
    op0(0, 1, 4'd2, 32'h0, 4'hF);
    i0.a_cs = 1; i0.a_we = 1; i0.a_addr = 4'd2; i0.a_wdata = 32'hFFFFFFFF; i0.a_be = 4'hF;
    i0.b_cs = 1; i0.b_we = 0; i0.b_addr = 4'd2;
    @(negedge clk); idle();
    checks++; if (i0.b_rvalid !== 1'b1 || i0.b_rdata !== 32'h0) begin errors++;
      $display("FAIL rdw_old: rvalid=%b rdata=%h want 1/00000000", i0.b_rvalid, i0.b_rdata); end
    op0(1, 0, 4'd2, 32'h0, 4'h0);
    checks++; if (i0.b_rdata !== 32'hFFFFFFFF) begin errors++;
      $display("FAIL rdw_after: rdata=%h want ffffffff", i0.b_rdata); end
    // dut1: new-data mode, 2-cycle latency
    op1(0, 1, 4'd2, 32'h0, 4'hF);
    i1.a_cs = 1; i1.a_we = 1; i1.a_addr = 4'd2; i1.a_wdata = 32'hFFFFFFFF; i1.a_be = 4'hF;
    i1.b_cs = 1; i1.b_we = 0; i1.b_addr = 4'd2;
    @(negedge clk); idle(); @(negedge clk);
    checks++; if (i1.b_rvalid !== 1'b1 || i1.b_rdata !== 32'hFFFFFFFF) begin errors++;
      $display("FAIL rdw_new: rvalid=%b rdata=%h want 1/ffffffff", i1.b_rvalid, i1.b_rdata); end
    i1.a_cs = 1; i1.a_we = 1; i1.a_addr = 4'd2; i1.a_wdata = 32'h0; i1.a_be = 4'b0011;
    i1.b_cs = 1; i1.b_we = 0; i1.b_addr = 4'd2;
    @(negedge clk); idle(); @(negedge clk);
    checks++; if (i1.b_rdata !== 32'hFFFF0000) begin errors++;
      $display("FAIL rdw_merge: rdata=%h want ffff0000", i1.b_rdata); end
  endtask

  task automatic test_collision();
    op0(0, 1, 4'd7, 32'h0, 4'hF);
    i0.a_cs = 1; i0.a_we = 1; i0.a_addr = 4'd7; i0.a_wdata = 32'h000000AA; i0.a_be = 4'b0001;
    i0.b_cs = 1; i0.b_we = 1; i0.b_addr = 4'd7; i0.b_wdata = 32'h0000BBCC; i0.b_be = 4'b0011;
    @(negedge clk); idle();
    op0(0, 0, 4'd7, 32'h0, 4'h0);
    checks++; if (i0.a_rdata !== 32'h0000BBAA) begin errors++;
      $display("FAIL wr_collide1: rdata=%h want 0000bbaa", i0.a_rdata); end
    op0(0, 1, 4'd7, 32'h0, 4'hF);
    i0.a_cs = 1; i0.a_we = 1; i0.a_addr = 4'd7; i0.a_wdata = 32'h11111111; i0.a_be = 4'b1100;
    i0.b_cs = 1; i0.b_we = 1; i0.b_addr = 4'd7; i0.b_wdata = 32'h22222222; i0.b_be = 4'b0110;
    @(negedge clk); idle();
    op0(1, 0, 4'd7, 32'h0, 4'h0);
    checks++; if (i0.b_rdata !== 32'h11112200) begin errors++;
      $display("FAIL wr_collide2: rdata=%h want 11112200", i0.b_rdata); end
  endtask

  task automatic test_out_of_range();
    op0(1, 1, 4'd11, 32'h0BADC0DE, 4'hF);
    op0(1, 0, 4'd11, 32'h0, 4'h0);
    checks++; if (i0.b_rvalid !== 1'b1 || i0.b_rdata !== 32'h0BADC0DE) begin errors++;
      $display("FAIL last_word: rvalid=%b rdata=%h want 1/0badc0de", i0.b_rvalid, i0.b_rdata); end
    op0(0, 1, 4'd13, 32'hCAFEF00D, 4'hF);
    op0(0, 0, 4'd13, 32'h0, 4'h0);
    checks++; if (i0.a_rvalid !== 1'b1 || i0.a_rdata !== 32'h0) begin errors++;
      $display("FAIL oor_read: rvalid=%b rdata=%h want 1/00000000", i0.a_rvalid, i0.a_rdata); end
    op0(1, 0, 4'd12, 32'h0, 4'h0);
    checks++; if (i0.b_rvalid !== 1'b1 || i0.b_rdata !== 32'h0) begin errors++;
      $display("FAIL oor_depth: rvalid=%b rdata=%h want 1/00000000", i0.b_rvalid, i0.b_rdata); end
  endtask

  task automatic test_cs_low();
    i0.a_cs = 0; i0.a_we = 0; i0.a_addr = 4'd3;
    @(negedge clk); idle();
    checks++; if (i0.a_rvalid !== 1'b0 || i0.a_rdata !== 32'h0) begin errors++;
      $display("FAIL cs_low: rvalid=%b rdata=%h want 0/00000000", i0.a_rvalid, i0.a_rdata); end
  endtask

  task automatic test_both_read();
    i0.a_cs = 1; i0.a_we = 0; i0.a_addr = 4'd3;
    i0.b_cs = 1; i0.b_we = 0; i0.b_addr = 4'd3;
    @(negedge clk); idle();
    checks++; if (i0.a_rvalid !== 1'b1 || i0.b_rvalid !== 1'b1 ||
                  i0.a_rdata !== 32'hDEADBEEF || i0.b_rdata !== 32'hDEADBEEF) begin errors++;
      $display("FAIL both_read: a=%b/%h b=%b/%h want 1/deadbeef both",
               i0.a_rvalid, i0.a_rdata, i0.b_rvalid, i0.b_rdata); end
  endtask

  task automatic test_back_to_back();
    logic [3:0]  ad [3];
    logic [31:0] ex [3];
    ad[0] = 4'd3; ad[1] = 4'd5; ad[2] = 4'd7;
    ex[0] = 32'hDEADBEEF; ex[1] = 32'h11BB33DD; ex[2] = 32'h11112200;
    for (int k = 0; k < 4; k++) begin
      if (k < 3) begin i0.a_cs = 1; i0.a_we = 0; i0.a_addr = ad[k]; end
      else idle();
      @(negedge clk);
      checks++;
      if (k < 3) begin
        if (i0.a_rvalid !== 1'b1 || i0.a_rdata !== ex[k]) begin errors++;
          $display("FAIL b2b_%0d: rvalid=%b rdata=%h want 1/%h", k, i0.a_rvalid, i0.a_rdata, ex[k]); end
      end else if (i0.a_rvalid !== 1'b0) begin errors++;
        $display("FAIL b2b_end: rvalid=%b want 0", i0.a_rvalid); end
    end
  endtask

  task automatic test_latency2();
    logic        ev;
    logic [31:0] ed;
    for (int k = 0; k < 3; k++) op1(0, 1, 4'(k), 32'hA0 + 32'(k), 4'hF);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      ev = (k >= 2 && k <= 4);
      ed = 32'hA0 + 32'(k - 2);
      checks++;
      if (i1.a_rvalid !== ev || (ev && i1.a_rdata !== ed)) begin errors++;
        $display("FAIL lat2_c%0d: rvalid=%b rdata=%h want %b/%h", k, i1.a_rvalid, i1.a_rdata, ev, ed); end
      if (k < 3) begin i1.a_cs = 1; i1.a_we = 0; i1.a_addr = 4'(k); end
      else idle();
    end
    // reset pulse while a read is in flight
    i1.a_cs = 1; i1.a_we = 0; i1.a_addr = 4'd0;
    @(negedge clk);
    i1.a_addr = 4'd1; rst1 = 1;
    @(negedge clk);
    rst1 = 0; idle();
    checks++; if (i1.a_rdata !== 32'h0) begin errors++;
      $display("FAIL midrst_rdata: rdata=%h want 00000000", i1.a_rdata); end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checks++; if (i1.a_rvalid !== 1'b0) begin errors++;
        $display("FAIL midrst_rvalid_%0d: rvalid=%b want 0", k, i1.a_rvalid); end
    end
    wait_ready();
  endtask

`ifdef DP_RAM_BW_INIT_CLEAR_EN
  task automatic test_init_clear();
    int nbusy;
    for (int k = 0; k < 16; k++) op1(0, 1, 4'(k), 32'h100 + 32'(k), 4'hF);
    rst1 = 1;
    @(negedge clk); @(negedge clk);
    rst1 = 0;
    nbusy = 0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (busy1) nbusy++;
      checks++; if (i1.a_rvalid !== 1'b0) begin errors++;
        $display("FAIL busy_rvalid_c%0d: rvalid=%b want 0", c, i1.a_rvalid); end
      if (c == 2) begin i1.a_cs = 1; i1.a_we = 0; i1.a_addr = 4'd3; end
      else idle();
    end
    checks++; if (nbusy != 16) begin errors++;
      $display("FAIL busy_len: init_busy high %0d cycles want 16", nbusy); end
    for (int k = 0; k < 16; k++) begin
      op1(1, 0, 4'(k), 32'h0, 4'h0);
      @(negedge clk);
      checks++; if (i1.b_rvalid !== 1'b1 || i1.b_rdata !== 32'h0) begin errors++;
        $display("FAIL cleared_%0d: rvalid=%b rdata=%h want 1/00000000", k, i1.b_rvalid, i1.b_rdata); end
    end
  endtask
`endif

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    idle();
    rst0 = 1; rst1 = 1;
    repeat (3) @(negedge clk);
    test_reset();
    test_write_read();
    test_byte_enable();
    test_rdw();
    test_collision();
    test_out_of_range();
    test_cs_low();
    test_both_read();
    test_back_to_back();
    test_latency2();
`ifdef DP_RAM_BW_INIT_CLEAR_EN
    test_init_clear();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
